// File: rtl/dataplane_pkg.sv
// Shared match-action dataplane types.
// Action entry layout, table geometry and executor FSM states.
package dataplane_pkg;

  localparam int ACTION_TABLE_DEPTH = 1024;
  localparam int ACTION_IDX_W       = 10;
  localparam int ACTION_PORT_W      = 4;
  localparam int FLOW_ID_W          = 16;

  typedef struct packed {
    logic                     valid;
    logic [FLOW_ID_W-1:0]     flow_id;
    logic                     drop;
    logic                     forward;
    logic                     trap;
    logic                     count;
    logic                     modify;
    logic [ACTION_PORT_W-1:0] out_port;
  } action_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FWD,
    S_DROP
  } ex_state_e;

endpackage

// File: rtl/action_stats.sv
// Four 32-bit wrapping statistics counters.
// Ports: clk, rst_n, *_inc_i strobes, *_cnt_o counter values.
module action_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fwd_inc_i,
  input  logic        drop_inc_i,
  input  logic        miss_inc_i,
  input  logic        hit_inc_i,
  output logic [31:0] fwd_cnt_o,
  output logic [31:0] drop_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] hit_cnt_o
);

  logic [31:0] fwd_q;
  logic [31:0] drop_q;
  logic [31:0] miss_q;
  logic [31:0] hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q  <= '0;
      drop_q <= '0;
      miss_q <= '0;
      hit_q  <= '0;
    end else begin
      if (fwd_inc_i)  fwd_q  <= fwd_q + 32'd1;
      if (drop_inc_i) drop_q <= drop_q + 32'd1;
      if (miss_inc_i) miss_q <= miss_q + 32'd1;
      if (hit_inc_i)  hit_q  <= hit_q + 32'd1;
    end
  end

  assign fwd_cnt_o  = fwd_q;
  assign drop_cnt_o = drop_q;
  assign miss_cnt_o = miss_q;
  assign hit_cnt_o  = hit_q;

endmodule

// File: rtl/action_executor.sv
// Action table reader: steers one packet per lookup to TX or drop.
// Ports: meta in, table read port, AXIS in/out, trap pulse, stats.
module action_executor
  import dataplane_pkg::*;
#(
  parameter int                       DATA_W       = 64,
  parameter bit                       DEFAULT_DROP = 1'b1,
  parameter logic [ACTION_PORT_W-1:0] DEFAULT_PORT = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       meta_valid,
  output logic                       meta_ready,
  input  logic                       flow_hit,
  input  logic [FLOW_ID_W-1:0]       flow_id,
  output logic                       tbl_rd_en,
  output logic [ACTION_IDX_W-1:0]    tbl_rd_addr,
  input  logic [$bits(action_t)-1:0] tbl_rd_data,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  output logic [ACTION_PORT_W-1:0]   m_tdest,
  output logic                       trap_valid,
  output logic [FLOW_ID_W-1:0]       trap_flow_id,
  output logic [31:0]                fwd_cnt,
  output logic [31:0]                drop_cnt,
  output logic [31:0]                miss_cnt,
  output logic [31:0]                hit_cnt
);

  ex_state_e                state_q, state_d;
  logic                     hit_q;
  logic [FLOW_ID_W-1:0]     fid_q;
  logic [ACTION_PORT_W-1:0] dest_q, dest_d;
  logic                     fwd_inc, drop_inc;
  logic                     miss_inc, hit_inc;

  action_t ent;
  logic    applies;
  logic    sel_fwd;
  logic    sel_drop;
  logic    unused_modify;

  assign ent           = action_t'(tbl_rd_data);
  assign unused_modify = ent.modify;

  // Index aliasing: the stored flow id must match the full latched id.
  assign applies  = hit_q && ent.valid && (ent.flow_id == fid_q);
  assign sel_fwd  = applies && ent.forward && !ent.drop;
  assign sel_drop = applies && !(ent.forward && !ent.drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hit_q   <= 1'b0;
      fid_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      if (state_q == S_IDLE && meta_valid) begin
        hit_q <= flow_hit;
        fid_q <= flow_id;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    fwd_inc  = 1'b0;
    drop_inc = 1'b0;
    miss_inc = 1'b0;
    hit_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (meta_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        hit_inc = applies && ent.count;
        unique case (1'b1)
          sel_fwd: begin
            state_d = S_FWD;
            dest_d  = ent.out_port;
            fwd_inc = 1'b1;
          end
          sel_drop: begin
            state_d  = S_DROP;
            drop_inc = 1'b1;
          end
          !applies: begin
            miss_inc = 1'b1;
            if (DEFAULT_DROP) begin
              state_d  = S_DROP;
              drop_inc = 1'b1;
            end else begin
              state_d = S_FWD;
              dest_d  = DEFAULT_PORT;
              fwd_inc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_FWD: begin
        if (s_tvalid && m_tready && s_tlast) state_d = S_IDLE;
      end
      S_DROP: begin
        if (s_tvalid && s_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    meta_ready  = 1'b0;
    tbl_rd_en   = 1'b0;
    tbl_rd_addr = '0;
    s_tready    = 1'b0;
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tlast     = 1'b0;
    trap_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        meta_ready = 1'b1;
        if (meta_valid && flow_hit) begin
          tbl_rd_en   = 1'b1;
          tbl_rd_addr = flow_id[ACTION_IDX_W-1:0];
        end
      end
      S_LOOKUP: begin
        trap_valid = applies && ent.trap;
      end
      S_FWD: begin
        m_tvalid = s_tvalid;
        s_tready = m_tready;
        m_tdata  = s_tdata;
        m_tlast  = s_tlast;
      end
      S_DROP: begin
        s_tready = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap_flow_id = trap_valid ? fid_q : '0;
  assign m_tdest      = dest_q;

  action_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .fwd_inc_i  (fwd_inc),
    .drop_inc_i (drop_inc),
    .miss_inc_i (miss_inc),
    .hit_inc_i  (hit_inc),
    .fwd_cnt_o  (fwd_cnt),
    .drop_cnt_o (drop_cnt),
    .miss_cnt_o (miss_cnt),
    .hit_cnt_o  (hit_cnt)
  );

endmodule
